// File: rtl/iso14443a_tag_rx_decoder_pkg.sv
//==============================================================================
// Module   : iso14443a_tag_rx_decoder_pkg
// Brief    : Shared sequence codes, FSM state encoding and bit-timing
//            constants for the ISO14443-A tag response decoder.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package iso14443a_tag_rx_decoder_pkg;

   // One Manchester bit spans 8 slots, split into two 4-slot halves
   localparam int c_SLOTS_PER_BIT = 8;
   localparam int c_HALF_SLOTS    = 4;

   // Modulation sequences recognised per bit period
   typedef enum logic [1:0] {
      SEQ_D    = 2'd0,   // first half modulated  -> logic 1
      SEQ_E    = 2'd1,   // second half modulated -> logic 0
      SEQ_F    = 2'd2,   // no modulation         -> end of frame
      SEQ_COLL = 2'd3    // both halves modulated -> collision, read as 1
   } seq_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SOF  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   // Map the two half-bit modulation counts onto a sequence code
   function automatic seq_t classify(input logic [2:0] m1,
                                     input logic [2:0] m2,
                                     input logic [2:0] thr);
      logic h1;
      logic h2;
      h1 = (m1 >= thr);
      h2 = (m2 >= thr);
      case ({h1, h2})
         2'b10:   classify = SEQ_D;
         2'b01:   classify = SEQ_E;
         2'b11:   classify = SEQ_COLL;
         default: classify = SEQ_F;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/iso14443a_tag_rx_decoder_halfbit_classifier.sv
//==============================================================================
// Module   : iso14443a_tag_rx_decoder_halfbit_classifier
// Brief    : Tracks the slot position inside a bit, counts modulated slots in
//            each half and reports the sequence code on the last slot.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module iso14443a_tag_rx_decoder_halfbit_classifier
   import iso14443a_tag_rx_decoder_pkg::*;
#(
   parameter int HALF_THRESH = 2
)(
   input  logic osc_clk,
   input  logic nreset,
   input  logic enable,
   input  logic active,       // decoder is inside SOF or DATA
   input  logic slot_strobe,
   input  logic curbit,
   output logic bit_done,     // combinational: this strobe closes a bit
   output seq_t seq           // combinational: sequence of the closing bit
);

   localparam logic [2:0] c_THR      = 3'(HALF_THRESH);
   localparam logic [2:0] c_LAST_IDX = 3'(c_SLOTS_PER_BIT - 1);
   localparam logic [2:0] c_HALF_IDX = 3'(c_HALF_SLOTS);

   logic [2:0] r_slot_idx;
   logic [2:0] r_m1;
   logic [2:0] r_m2;
   logic [2:0] w_m2_final;
   logic [2:0] w_cur;

   assign w_cur      = {2'b00, curbit};
   // The final slot belongs to the second half, so fold it in before deciding
   assign w_m2_final = r_m2 + w_cur;
   assign bit_done   = enable && active && slot_strobe && (r_slot_idx == c_LAST_IDX);
   assign seq        = classify(r_m1, w_m2_final, c_THR);

   // Slot index and half-bit modulation counters, advanced only on strobes
   always_ff @(negedge osc_clk or negedge nreset) begin
      if (!nreset) begin
         r_slot_idx <= '0;
         r_m1       <= '0;
         r_m2       <= '0;
      end else if (!enable) begin
         r_slot_idx <= '0;
         r_m1       <= '0;
         r_m2       <= '0;
      end else if (slot_strobe) begin
         if (!active) begin
            // The first modulated slot while idle is slot 0 of the SOF bit
            if (curbit) begin
               r_slot_idx <= 3'd1;
               r_m1       <= 3'd1;
               r_m2       <= '0;
            end
         end else if (r_slot_idx == c_LAST_IDX) begin
            r_slot_idx <= '0;
            r_m1       <= '0;
            r_m2       <= '0;
         end else begin
            r_slot_idx <= r_slot_idx + 3'd1;
            if (r_slot_idx < c_HALF_IDX) begin
               r_m1 <= r_m1 + w_cur;
            end else begin
               r_m2 <= r_m2 + w_cur;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/iso14443a_tag_rx_decoder.sv
//==============================================================================
// Module   : iso14443a_tag_rx_decoder
// Brief    : ISO14443-A tag response decoder: SOF detection, LSB-first byte
//            assembly, odd-parity check, collision and overflow flags.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module iso14443a_tag_rx_decoder
   import iso14443a_tag_rx_decoder_pkg::*;
#(
   parameter int HALF_THRESH = 2,
   parameter int MAX_BYTES   = 64
)(
   input  logic       osc_clk,
   input  logic       nreset,
   input  logic       enable,
   input  logic       slot_strobe,
   input  logic       curbit,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       parity_err,
   output logic [2:0] last_bits,
   output logic       frame_start,
   output logic       frame_end,
   output logic       collision,
   output logic       overflow
);

   localparam int                 c_CNT_W   = $clog2(MAX_BYTES + 1);
   localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_BYTES);

   state_t             r_state, w_state_nxt;
   logic [7:0]         r_shift, w_shift_nxt;
   logic [3:0]         r_bit_idx, w_bit_idx_nxt;
   logic [c_CNT_W-1:0] r_byte_cnt, w_byte_cnt_nxt, w_cnt_inc;

   logic [7:0] w_byte_data_nxt;
   logic       w_byte_valid_nxt, w_parity_err_nxt, w_frame_start_nxt, w_frame_end_nxt;
   logic       w_collision_nxt, w_overflow_nxt;
   logic [2:0] w_last_bits_nxt;

   logic       w_active, w_bit_done, w_bit;
   seq_t       w_seq;

   assign w_active  = (r_state != ST_IDLE);
   assign w_bit     = (w_seq != SEQ_E);
   assign w_cnt_inc = r_byte_cnt + c_CNT_W'(1);

   iso14443a_tag_rx_decoder_halfbit_classifier #(
      .HALF_THRESH (HALF_THRESH)
   ) u_classifier (
      .osc_clk     (osc_clk),
      .nreset      (nreset),
      .enable      (enable),
      .active      (w_active),
      .slot_strobe (slot_strobe),
      .curbit      (curbit),
      .bit_done    (w_bit_done),
      .seq         (w_seq)
   );

   // State register
   always_ff @(negedge osc_clk or negedge nreset) begin
      if (!nreset) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state, datapath and output decisions for each completed bit
   always_comb begin
      w_state_nxt       = r_state;
      w_shift_nxt       = r_shift;
      w_bit_idx_nxt     = r_bit_idx;
      w_byte_cnt_nxt    = r_byte_cnt;
      w_byte_data_nxt   = byte_data;
      w_byte_valid_nxt  = 1'b0;
      w_parity_err_nxt  = parity_err;
      w_last_bits_nxt   = last_bits;
      w_frame_start_nxt = 1'b0;
      w_frame_end_nxt   = 1'b0;
      w_collision_nxt   = collision;
      w_overflow_nxt    = overflow;
      if (!enable) begin
         // Leaving listen mode silently; sticky flags survive until next SOF
         w_state_nxt    = ST_IDLE;
         w_shift_nxt    = '0;
         w_bit_idx_nxt  = '0;
         w_byte_cnt_nxt = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (slot_strobe && curbit) w_state_nxt = ST_SOF;
            end
            ST_SOF: begin
               if (w_bit_done) begin
                  if (w_seq == SEQ_D) begin
                     w_state_nxt       = ST_DATA;
                     w_frame_start_nxt = 1'b1;
                     w_collision_nxt   = 1'b0;
                     w_overflow_nxt    = 1'b0;
                     w_shift_nxt       = '0;
                     w_bit_idx_nxt     = '0;
                     w_byte_cnt_nxt    = '0;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end
            end
            ST_DATA: begin
               if (w_bit_done) begin
                  if (w_seq == SEQ_F) begin
                     // End of frame: flush any partial byte first
                     if (r_bit_idx == 4'd8) begin
                        w_byte_valid_nxt = 1'b1;
                        w_byte_data_nxt  = r_shift;
                        w_parity_err_nxt = 1'b1;
                        w_last_bits_nxt  = 3'd0;
                     end else if (r_bit_idx != 4'd0) begin
                        w_byte_valid_nxt = 1'b1;
                        w_byte_data_nxt  = r_shift >> (4'd8 - r_bit_idx);
                        w_parity_err_nxt = 1'b0;
                        w_last_bits_nxt  = r_bit_idx[2:0];
                     end
                     w_frame_end_nxt = 1'b1;
                     w_state_nxt     = ST_IDLE;
                     w_bit_idx_nxt   = '0;
                     w_byte_cnt_nxt  = '0;
                  end else begin
                     if (w_seq == SEQ_COLL) w_collision_nxt = 1'b1;
                     if (r_bit_idx == 4'd8) begin
                        w_byte_valid_nxt = 1'b1;
                        w_byte_data_nxt  = r_shift;
                        w_parity_err_nxt = (w_bit != ~^r_shift);
                        w_last_bits_nxt  = 3'd0;
                        w_bit_idx_nxt    = '0;
                        w_byte_cnt_nxt   = w_cnt_inc;
                        if (w_cnt_inc == c_MAX_CNT) begin
                           w_overflow_nxt  = 1'b1;
                           w_frame_end_nxt = 1'b1;
                           w_state_nxt     = ST_IDLE;
                           w_byte_cnt_nxt  = '0;
                        end
                     end else begin
                        // Shift in from the top so the first bit ends at bit 0
                        w_shift_nxt   = {w_bit, r_shift[7:1]};
                        w_bit_idx_nxt = r_bit_idx + 4'd1;
                     end
                  end
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Datapath and registered outputs
   always_ff @(negedge osc_clk or negedge nreset) begin
      if (!nreset) begin
         r_shift     <= '0;
         r_bit_idx   <= '0;
         r_byte_cnt  <= '0;
         byte_data   <= '0;
         byte_valid  <= 1'b0;
         parity_err  <= 1'b0;
         last_bits   <= '0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         collision   <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         r_shift     <= w_shift_nxt;
         r_bit_idx   <= w_bit_idx_nxt;
         r_byte_cnt  <= w_byte_cnt_nxt;
         byte_data   <= w_byte_data_nxt;
         byte_valid  <= w_byte_valid_nxt;
         parity_err  <= w_parity_err_nxt;
         last_bits   <= w_last_bits_nxt;
         frame_start <= w_frame_start_nxt;
         frame_end   <= w_frame_end_nxt;
         collision   <= w_collision_nxt;
         overflow    <= w_overflow_nxt;
      end
   end

endmodule

`default_nettype wire
